// File: rtl/stream_serializer_if.sv
// Wide-in / narrow-out valid/ready stream bundle for the serializer.
// The master drives wide words in and takes lanes out; the slave is the serializer.
interface stream_serializer_if #(
  parameter int LANES = 4,
  parameter int W     = 8,
  parameter int CNT_W = $clog2(LANES + 1)
);
  logic                 input_valid;
  logic [LANES*W-1:0]   input_payload;
  logic [CNT_W-1:0]     input_count;
  logic                 input_last;
  logic                 input_ready;
  logic                 output_valid;
  logic [W-1:0]         output_payload;
  logic                 output_last;
  logic                 output_ready;

  modport master (
    output input_valid, input_payload, input_count, input_last, output_ready,
    input  input_ready, output_valid, output_payload, output_last
  );

  modport slave (
    input  input_valid, input_payload, input_count, input_last, output_ready,
    output input_ready, output_valid, output_payload, output_last
  );
endinterface

// File: rtl/stream_serializer.sv
// Width-down converter: takes one LANES-wide word, emits its first input_count
// lanes one per transfer (lane 0 first) with no bubbles between words.
module stream_serializer #(
  parameter int LANES = 4,
  parameter int W     = 8,
  parameter int CNT_W = $clog2(LANES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_serializer_if.slave  s
);
  localparam int                IDX_W   = $clog2(LANES);
  localparam logic [CNT_W-1:0]  LANES_C = CNT_W'(LANES);

  logic [LANES*W-1:0] hold_q,   hold_d;
  logic               last_q,   last_d;
  logic [IDX_W-1:0]   idx_q,    idx_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic               accept, emit;
  logic [W-1:0]       lane_sel;

  // The only combinational input->output path: output_ready opens the input
  // on the final lane so the next word lands on the same edge.
  assign s.input_ready    = rst_n && ((remain_q == '0) ||
                                      ((remain_q == CNT_W'(1)) && s.output_ready));
  assign s.output_valid   = (remain_q != '0);
  assign s.output_payload = lane_sel;
  assign s.output_last    = last_q && (remain_q == CNT_W'(1));

  assign accept = s.input_valid && s.input_ready;
  assign emit   = s.output_valid && s.output_ready;

  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx_q == IDX_W'(i)) lane_sel = hold_q[i*W +: W];
    end
  end

  always_comb begin
    hold_d   = hold_q;
    last_d   = last_q;
    idx_d    = idx_q;
    remain_d = remain_q;
    if (accept) begin
      hold_d   = s.input_payload;
      last_d   = s.input_last;
      idx_d    = '0;
      remain_d = (s.input_count > LANES_C) ? LANES_C : s.input_count;
    end else if (emit) begin
      idx_d    = idx_q + IDX_W'(1);
      remain_d = remain_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      last_q   <= 1'b0;
      idx_q    <= '0;
      remain_q <= '0;
    end else begin
      hold_q   <= hold_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
    end
  end
endmodule
